// File: rtl/tick_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tick_timer
//  Purpose  : Decimal timebase generator. A prescaler divides clk down to a
//             1 us tick. A chain of decade counters then produces ticks every
//             10^k us. A minute counter pulses tim_1m every 60 s. An optional
//             interval timer counts ticks of a selectable decade.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CLK_FREQ     clock frequency in MHz (1..255)
//    NUM_DECADES  number of decade tick outputs (1..7)
//    IVL_W        interval counter width (4..32)
//  Ports
//    clk          sole clock
//    rst_n        asynchronous active-low reset
//    sync_clr     synchronous clear of the timebase; also aborts the interval
//    tick         tick[k] pulses for one cycle every 10^k us (registered)
//    tim_1m       one-cycle pulse every 60 s (0 when NUM_DECADES < 7)
//    ivl_load     interval start/restart strobe
//    ivl_val      interval length in ticks of the selected decade
//    ivl_sel      decade used as interval time base (>= NUM_DECADES -> 0)
//    ivl_busy     interval running
//    ivl_expire   one-cycle pulse when the interval has elapsed
//  Build option
//    TICK_TIMER_IVL_EN  when defined, the interval timer is compiled in;
//                       otherwise ivl_busy/ivl_expire are tied to 0.
// ============================================================================
module tick_timer #(
    parameter logic [7:0] CLK_FREQ    = 8'd125,
    parameter int         NUM_DECADES = 7,
    parameter int         IVL_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sync_clr,
    output logic [NUM_DECADES-1:0] tick,
    output logic                   tim_1m,
    input  logic                   ivl_load,
    input  logic [IVL_W-1:0]       ivl_val,
    input  logic [2:0]             ivl_sel,
    output logic                   ivl_busy,
    output logic                   ivl_expire
);

    localparam logic [7:0] c_pre_max = CLK_FREQ - 8'd1;

    // ------------------------------------------------------------------
    // Timebase
    // ------------------------------------------------------------------
    logic [7:0]             r_pre;
    logic [NUM_DECADES-1:0] r_tick;
    logic [NUM_DECADES-1:0] w_tick_nxt;   // tick value to be registered
    logic [NUM_DECADES-1:0] w_dec_nine;   // bit k: decade k sits at 9
    logic                   w_pre_wrap;

    assign w_pre_wrap    = (r_pre == c_pre_max);
    assign w_dec_nine[0] = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= 8'd0;
        end else if (sync_clr || w_pre_wrap) begin
            r_pre <= 8'd0;
        end else begin
            r_pre <= r_pre + 8'd1;
        end
    end

    // Decade k advances on the (pre-register) tick of decade k-1, so that the
    // registered ticks of all decades line up in the same cycle.
    for (genvar k = 1; k < NUM_DECADES; k++) begin : g_dec
        logic [3:0] r_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= 4'd0;
            end else if (sync_clr) begin
                r_cnt <= 4'd0;
            end else if (w_tick_nxt[k-1]) begin
                r_cnt <= (r_cnt == 4'd9) ? 4'd0 : r_cnt + 4'd1;
            end
        end

        assign w_dec_nine[k] = (r_cnt == 4'd9);
    end

    // Tick k fires when the prescaler wraps and every lower decade is at 9;
    // computed from w_dec_nine rather than chained to keep the net acyclic.
    for (genvar k = 0; k < NUM_DECADES; k++) begin : g_tick_nxt
        assign w_tick_nxt[k] = w_pre_wrap & (&w_dec_nine[k:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick <= '0;
        end else if (sync_clr) begin
            r_tick <= '0;
        end else begin
            r_tick <= w_tick_nxt;
        end
    end

    assign tick = r_tick;

    // ------------------------------------------------------------------
    // Minute counter (only meaningful when the 1 s decade exists)
    // ------------------------------------------------------------------
    if (NUM_DECADES == 7) begin : g_min
        logic [5:0] r_min;
        logic       r_tim_1m;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_min    <= 6'd0;
                r_tim_1m <= 1'b0;
            end else if (sync_clr) begin
                r_min    <= 6'd0;
                r_tim_1m <= 1'b0;
            end else begin
                r_tim_1m <= w_tick_nxt[NUM_DECADES-1] & (r_min == 6'd59);
                if (w_tick_nxt[NUM_DECADES-1]) begin
                    r_min <= (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
                end
            end
        end

        assign tim_1m = r_tim_1m;
    end else begin : g_no_min
        assign tim_1m = 1'b0;
    end

`ifdef TICK_TIMER_IVL_EN
    // ------------------------------------------------------------------
    // Interval timer
    // ------------------------------------------------------------------
    // The load request is captured first and acted on one cycle later. This
    // lines the load up against the registered tick of the same cycle, so a
    // load coinciding with a tick wins and that tick is not counted.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ivl_state_t;

    localparam logic [2:0] c_num_dec = 3'(NUM_DECADES);

    ivl_state_t       r_state;
    ivl_state_t       w_state_nxt;
    logic             r_ld;
    logic [IVL_W-1:0] r_ld_val;
    logic [2:0]       r_ld_sel;
    logic [IVL_W-1:0] r_cnt;
    logic [IVL_W-1:0] w_cnt_nxt;
    logic [2:0]       r_sel;
    logic [2:0]       w_sel_nxt;
    logic             r_expire;
    logic             w_expire_nxt;
    logic [2:0]       w_sel_clamped;
    logic [7:0]       w_tick_pad;
    logic             w_sel_tick;

    assign w_sel_clamped = (ivl_sel >= c_num_dec) ? 3'd0 : ivl_sel;
    assign w_tick_pad    = {{(8-NUM_DECADES){1'b0}}, r_tick};
    assign w_sel_tick    = w_tick_pad[r_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld     <= 1'b0;
            r_ld_val <= '0;
            r_ld_sel <= 3'd0;
        end else begin
            // A clear in the same cycle as a load discards that load.
            r_ld     <= ivl_load & ~sync_clr;
            r_ld_val <= ivl_val;
            r_ld_sel <= w_sel_clamped;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_sel    <= 3'd0;
            r_expire <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sel    <= w_sel_nxt;
            r_expire <= w_expire_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_sel_nxt    = r_sel;
        w_expire_nxt = 1'b0;
        if (sync_clr) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else if (r_ld) begin
            if (r_ld_val == '0) begin
                // Zero-length interval: expire at once, never busy.
                w_state_nxt  = ST_IDLE;
                w_cnt_nxt    = '0;
                w_expire_nxt = 1'b1;
            end else begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = r_ld_val;
                w_sel_nxt   = r_ld_sel;
            end
        end else if ((r_state == ST_RUN) && w_sel_tick) begin
            if (r_cnt == IVL_W'(1)) begin
                w_state_nxt  = ST_IDLE;
                w_cnt_nxt    = '0;
                w_expire_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt - IVL_W'(1);
            end
        end
    end

    assign ivl_busy   = (r_state == ST_RUN);
    assign ivl_expire = r_expire;
`else
    logic w_ivl_unused;
    assign w_ivl_unused = ^{ivl_load, ivl_val, ivl_sel};
    assign ivl_busy     = 1'b0;
    assign ivl_expire   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tick_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tick_timer
//  Purpose  : Directed self-checking bench for tick_timer. Instance "a" runs
//             at 125 MHz with all 7 decades; instance "b" runs at 1 MHz with
//             5 decades so the upper decades are reached within a short run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tick_timer;

`ifdef TICK_TIMER_IVL_EN
    localparam bit IVL = 1'b1;
`else
    localparam bit IVL = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_sync, a_tim, a_load, a_busy, a_exp;
    logic [6:0]  a_tick;
    logic [15:0] a_val;
    logic [2:0]  a_sel;
    logic        b_sync, b_tim, b_load, b_busy, b_exp;
    logic [4:0]  b_tick;
    logic [7:0]  b_val;
    logic [2:0]  b_sel;

    int cyc;
    int n_vec;
    int n_err;
    int a_exp_cnt;
    int a_busy_cnt;

    tick_timer #(.CLK_FREQ(8'd125), .NUM_DECADES(7), .IVL_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .sync_clr(a_sync), .tick(a_tick),
        .tim_1m(a_tim), .ivl_load(a_load), .ivl_val(a_val), .ivl_sel(a_sel),
        .ivl_busy(a_busy), .ivl_expire(a_exp)
    );

    tick_timer #(.CLK_FREQ(8'd1), .NUM_DECADES(5), .IVL_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .sync_clr(b_sync), .tick(b_tick),
        .tim_1m(b_tim), .ivl_load(b_load), .ivl_val(b_val), .ivl_sel(b_sel),
        .ivl_busy(b_busy), .ivl_expire(b_exp)
    );

    // Cycle n is the n-th rising edge after reset release.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Count expire pulses and busy cycles of instance a (reset cycles excluded).
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_exp)  a_exp_cnt  <= a_exp_cnt + 1;
            if (a_busy) a_busy_cnt <= a_busy_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to #1 after rising edge n.
    task automatic to_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 20000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc != n) chk("cycle_reach", 32'(cyc), 32'(n));
    endtask

    initial begin
        rst_n  = 1'b0;
        a_sync = 1'b0; a_load = 1'b0; a_val = '0; a_sel = 3'd0;
        b_sync = 1'b0; b_load = 1'b0; b_val = '0; b_sel = 3'd0;
        n_vec = 0; n_err = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_tick", 32'(a_tick), 32'd0);
        chk("rst_a_tim",  32'(a_tim),  32'd0);
        chk("rst_a_busy", 32'(a_busy), 32'd0);
        chk("rst_a_exp",  32'(a_exp),  32'd0);
        chk("rst_b_tick", 32'(b_tick), 32'd0);
        rst_n = 1'b1;

        // Interval loads in cycle 10: a VAL=3 SEL=0; b VAL=4 SEL=7 (->0).
        to_cyc(9);
        a_load = 1'b1; a_val = 16'd3; a_sel = 3'd0;
        b_load = 1'b1; b_val = 8'd4;  b_sel = 3'd7;
        to_cyc(10);
        a_load = 1'b0; b_load = 1'b0;
        chk("a_busy_10", 32'(a_busy), 32'd0);
        to_cyc(11);
        chk("a_busy_11", 32'(a_busy), 32'(IVL));
        chk("b_busy_11", 32'(b_busy), 32'(IVL));
        to_cyc(14);
        chk("b_busy_14", 32'(b_busy), 32'(IVL));
        chk("b_exp_14",  32'(b_exp),  32'd0);
        to_cyc(15);
        chk("b_exp_15",  32'(b_exp),  32'(IVL));
        chk("b_busy_15", 32'(b_busy), 32'd0);
        to_cyc(16);
        chk("b_exp_16",  32'(b_exp),  32'd0);

        to_cyc(100);
        chk("b_tick_100", 32'(b_tick), 32'h07);
        to_cyc(124);
        chk("a_tick_124", 32'(a_tick), 32'h00);
        to_cyc(125);
        chk("a_tick_125", 32'(a_tick), 32'h01);
        to_cyc(126);
        chk("a_tick_126", 32'(a_tick), 32'h00);
        to_cyc(250);
        chk("a_tick_250", 32'(a_tick), 32'h01);
        to_cyc(375);
        chk("a_tick_375", 32'(a_tick), 32'h01);
        chk("a_busy_375", 32'(a_busy), 32'(IVL));
        to_cyc(376);
        chk("a_exp_376",  32'(a_exp),  32'(IVL));
        chk("a_busy_376", 32'(a_busy), 32'd0);
        to_cyc(377);
        chk("a_exp_377",  32'(a_exp),  32'd0);
        to_cyc(400);
        chk("a_busy_cnt_400", 32'(a_busy_cnt), IVL ? 32'd365 : 32'd0);
        chk("a_exp_cnt_400",  32'(a_exp_cnt),  IVL ? 32'd1 : 32'd0);

        to_cyc(1000);
        chk("b_tick_1000", 32'(b_tick), 32'h0F);
        to_cyc(1249);
        chk("a_tick_1249", 32'(a_tick), 32'h00);
        to_cyc(1250);
        chk("a_tick_1250", 32'(a_tick), 32'h03);

        // Run started at 1280, then sync_clr together with a load at 1300.
        to_cyc(1279);
        a_load = 1'b1; a_val = 16'd2; a_sel = 3'd0;
        to_cyc(1280);
        a_load = 1'b0;
        to_cyc(1299);
        chk("a_busy_1299", 32'(a_busy), 32'(IVL));
        a_sync = 1'b1; a_load = 1'b1; a_val = 16'd9;
        to_cyc(1300);
        a_sync = 1'b0; a_load = 1'b0;
        chk("a_busy_1300", 32'(a_busy), 32'd0);
        chk("a_tick_1300", 32'(a_tick), 32'h00);
        to_cyc(1301);
        chk("a_busy_1301", 32'(a_busy), 32'd0);
        to_cyc(1302);
        chk("a_busy_1302", 32'(a_busy), 32'd0);
        to_cyc(1375);
        chk("a_tick_1375", 32'(a_tick), 32'h00);
        to_cyc(1424);
        chk("a_tick_1424", 32'(a_tick), 32'h00);
        to_cyc(1425);
        chk("a_tick_1425", 32'(a_tick), 32'h01);

        // Zero-length load in cycle 1500.
        to_cyc(1499);
        a_load = 1'b1; a_val = 16'd0;
        to_cyc(1500);
        a_load = 1'b0;
        chk("a_busy_1500", 32'(a_busy), 32'd0);
        to_cyc(1501);
        chk("a_exp_1501",  32'(a_exp),  32'(IVL));
        chk("a_busy_1501", 32'(a_busy), 32'd0);
        to_cyc(1502);
        chk("a_exp_1502",  32'(a_exp),  32'd0);

        // VAL=2 at 1520, reloaded with VAL=5 at 1600.
        // Ticks 1675,1800,1925,2050,2175 -> expire 2176.
        to_cyc(1519);
        a_load = 1'b1; a_val = 16'd2;
        to_cyc(1520);
        a_load = 1'b0;
        to_cyc(1521);
        chk("a_busy_1521", 32'(a_busy), 32'(IVL));
        to_cyc(1599);
        a_load = 1'b1; a_val = 16'd5;
        to_cyc(1600);
        a_load = 1'b0;
        to_cyc(1676);
        chk("a_exp_1676",  32'(a_exp),  32'd0);
        chk("a_busy_1676", 32'(a_busy), 32'(IVL));
        to_cyc(2175);
        chk("a_exp_cnt_2175", 32'(a_exp_cnt), IVL ? 32'd2 : 32'd0);
        chk("a_busy_2175",    32'(a_busy),    32'(IVL));
        to_cyc(2176);
        chk("a_exp_2176",  32'(a_exp),  32'(IVL));
        chk("a_busy_2176", 32'(a_busy), 32'd0);
        to_cyc(2200);
        chk("a_exp_cnt_2200", 32'(a_exp_cnt), IVL ? 32'd3 : 32'd0);

        // Load coincident with the tick of cycle 2300: that tick is not counted.
        to_cyc(2299);
        a_load = 1'b1; a_val = 16'd1; a_sel = 3'd0;
        to_cyc(2300);
        a_load = 1'b0;
        chk("a_tick_2300", 32'(a_tick), 32'h01);
        to_cyc(2301);
        chk("a_busy_2301", 32'(a_busy), 32'(IVL));
        to_cyc(2425);
        chk("a_busy_2425", 32'(a_busy), 32'(IVL));
        chk("a_exp_2425",  32'(a_exp),  32'd0);
        to_cyc(2426);
        chk("a_exp_2426",  32'(a_exp),  32'(IVL));

        // SEL=1 captured at load; input changed afterwards. Next TICK[1] at 3800.
        to_cyc(2559);
        a_load = 1'b1; a_val = 16'd1; a_sel = 3'd1;
        to_cyc(2560);
        a_load = 1'b0; a_sel = 3'd0;
        to_cyc(2676);
        chk("a_busy_2676", 32'(a_busy), 32'(IVL));
        to_cyc(3800);
        chk("a_tick_3800", 32'(a_tick), 32'h03);
        to_cyc(3801);
        chk("a_exp_3801",  32'(a_exp),  32'(IVL));
        chk("a_busy_3801", 32'(a_busy), 32'd0);
        to_cyc(3900);
        chk("a_exp_cnt_3900", 32'(a_exp_cnt), IVL ? 32'd5 : 32'd0);

        to_cyc(10000);
        chk("b_tick_10000", 32'(b_tick), 32'h1F);
        chk("b_tim_10000",  32'(b_tim),  32'd0);
        chk("a_tim_10000",  32'(a_tim),  32'd0);
        to_cyc(10001);
        chk("b_tick_10001", 32'(b_tick), 32'h01);

        // Reset in the middle of a running interval.
        to_cyc(10049);
        a_load = 1'b1; a_val = 16'd2; a_sel = 3'd0;
        to_cyc(10050);
        a_load = 1'b0;
        to_cyc(10100);
        chk("a_busy_10100", 32'(a_busy), 32'(IVL));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_a_tick", 32'(a_tick), 32'd0);
        chk("arst_a_busy", 32'(a_busy), 32'd0);
        chk("arst_a_exp",  32'(a_exp),  32'd0);
        chk("arst_b_tick", 32'(b_tick), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        to_cyc(1);
        chk("rel_b_tick_1", 32'(b_tick), 32'h01);
        to_cyc(124);
        chk("rel_a_tick_124", 32'(a_tick), 32'h00);
        to_cyc(125);
        chk("rel_a_tick_125", 32'(a_tick), 32'h01);
        to_cyc(300);
        chk("rel_a_exp_cnt", 32'(a_exp_cnt), IVL ? 32'd5 : 32'd0);
        chk("rel_a_busy",    32'(a_busy),    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
